// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle CPU control FSM: state encoding,
// instruction decode constants, ALU op codes, mux select encodings and the
// packed control word the FSM drives toward the datapath.
// Honours OVERFLOW_TRAP_EN (adds the TRAP state when defined).
package ctrl_pkg;

    // Controller states; values are what state_dbg reports.
    typedef enum logic [4:0] {
        S_RST      = 5'd0,
        S_FETCH    = 5'd1,
        S_FETCH_W  = 5'd2,
        S_FETCH_L  = 5'd3,
        S_DECODE   = 5'd4,
        S_EXEC_R   = 5'd5,
        S_WB_R     = 5'd6,
        S_EXEC_I   = 5'd7,
        S_WB_I     = 5'd8,
        S_MEM_ADDR = 5'd9,
        S_MEM_RD   = 5'd10,
        S_MDR_LD   = 5'd11,
        S_WB_M     = 5'd12,
        S_MEM_WR   = 5'd13,
        S_BRANCH   = 5'd14,
        S_JUMP     = 5'd15
`ifdef OVERFLOW_TRAP_EN
        , S_TRAP   = 5'd16
`endif
    } state_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    // ALU operation codes
    localparam logic [2:0] ULA_NOP = 3'b000;
    localparam logic [2:0] ULA_ADD = 3'b001;
    localparam logic [2:0] ULA_SUB = 3'b010;
    localparam logic [2:0] ULA_AND = 3'b011;

    // ALU A-input select
    localparam logic ULAA_PC = 1'b0;
    localparam logic ULAA_A  = 1'b1;

    // ALU B-input select
    localparam logic [1:0] ULAB_B       = 2'd0;
    localparam logic [1:0] ULAB_FOUR    = 2'd1;
    localparam logic [1:0] ULAB_SEXT    = 2'd2;
    localparam logic [1:0] ULAB_SEXT_SH = 2'd3;

    // Register-bank write address select
    localparam logic [1:0] WREG_RT = 2'd0;
    localparam logic [1:0] WREG_RD = 2'd1;
    localparam logic [1:0] WREG_29 = 2'd2;
    localparam logic [1:0] WREG_31 = 2'd3;

    // Register-bank write data select
    localparam logic [1:0] MTR_ALUOUT = 2'd0;
    localparam logic [1:0] MTR_MDR    = 2'd1;
    localparam logic [1:0] MTR_SP     = 2'd2;

    // Next-PC source select
    localparam logic [1:0] PCS_ULA    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_EXC    = 2'd3;

    // Everything the FSM drives except the debug state view
    typedef struct packed {
        logic       pc_w;
        logic       mem_w;
        logic       ir_w;
        logic       reg_w;
        logic       ab_w;
        logic       aluout_w;
        logic       mdr_w;
        logic       epc_w;
        logic [2:0] ula_c;
        logic       m_ulaa;
        logic [1:0] m_ulab;
        logic [1:0] m_wreg;
        logic [1:0] memtoreg;
        logic [1:0] pc_source;
        logic       i_or_d;
    } ctrl_out_t;

    // R-type funct to ALU op; ULA_NOP marks an unsupported funct
    function automatic logic [2:0] funct_to_ula(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_ADD:  op = ULA_ADD;
            FN_SUB:  op = ULA_SUB;
            FN_AND:  op = ULA_AND;
            default: op = ULA_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath
// (slave): decoded instruction fields and ALU flags in, enables/selects out.
interface multicycle_ctrl_fsm_if;
    logic [5:0] OPCODE;
    logic [5:0] funct;
    logic       Of;
    logic       Zr;
    logic       PC_w;
    logic       MEM_w;
    logic       IR_w;
    logic       Reg_w;
    logic       AB_w;
    logic       aluOut_w;
    logic       MDR_w;
    logic       EPC_w;
    logic [2:0] ULA_c;
    logic       M_ULAA;
    logic [1:0] M_ULAB;
    logic [1:0] M_WREG;
    logic [1:0] MemtoReg;
    logic [1:0] PC_source;
    logic       i_or_d;
    logic [4:0] state_dbg;

    modport master (
        input  OPCODE, funct, Of, Zr,
        output PC_w, MEM_w, IR_w, Reg_w, AB_w, aluOut_w, MDR_w, EPC_w,
               ULA_c, M_ULAA, M_ULAB, M_WREG, MemtoReg, PC_source, i_or_d,
               state_dbg
    );

    modport slave (
        output OPCODE, funct, Of, Zr,
        input  PC_w, MEM_w, IR_w, Reg_w, AB_w, aluOut_w, MDR_w, EPC_w,
               ULA_c, M_ULAA, M_ULAB, M_WREG, MemtoReg, PC_source, i_or_d,
               state_dbg
    );
endinterface

// File: rtl/ctrl_wait_cnt.sv
// Loadable down-counter timing the memory wait states. Loaded with
// (cycles-1) on every state change; o_done is high on the last cycle.
module ctrl_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);
    logic [W-1:0] r_cnt;

    // Reload on state change, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multicycle CPU datapath (add, sub, and, addi,
// lw, sw, beq, bne, j). Outputs depend on the current state, plus funct in
// EXEC_R and OPCODE/Zr in BRANCH. All outputs are forced low while reset
// is high so an aborted instruction never fires a write.
// Optional feature macro: OVERFLOW_TRAP_EN (overflow in add/sub/addi
// diverts to TRAP, which saves EPC and jumps to the exception vector).
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2,     // memory latency in cycles, 1..3
    parameter int SP_INIT  = 227    // stack pointer loaded into r29 in RST
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_ctrl_fsm_if.master    bus
);
    // SP_INIT is consumed by the datapath's MemtoReg=2 source; the FSM only
    // selects it, so the value is carried here to keep one parameter set.
    localparam int SP_INIT_UNUSED = SP_INIT;

    // Counter preloads (cycles in state minus one)
    localparam logic [1:0] FETCH_W_LOAD = 2'(MEM_WAIT - 1);
    localparam logic [1:0] MEM_RD_LOAD  = 2'(MEM_WAIT);

    state_t     r_state;
    state_t     w_state_next;
    ctrl_out_t  w_out;
    ctrl_out_t  w_out_gated;
    logic [1:0] w_wait_load;
    logic       w_wait_done;
    logic       w_branch_taken;
    logic       w_funct_known;

    assign w_funct_known  = (funct_to_ula(bus.funct) != ULA_NOP);
    assign w_branch_taken = ((bus.OPCODE == OP_BEQ) &&  bus.Zr) ||
                            ((bus.OPCODE == OP_BNE) && !bus.Zr);

`ifndef OVERFLOW_TRAP_EN
    logic w_unused_of;
    assign w_unused_of = bus.Of;
`endif

    // Pick the counter preload for whichever wait state is being entered
    always_comb begin
        w_wait_load = 2'd0;
        if (w_state_next == S_FETCH_W) begin
            w_wait_load = FETCH_W_LOAD;
        end else if (w_state_next == S_MEM_RD) begin
            w_wait_load = MEM_RD_LOAD;
        end
    end

    ctrl_wait_cnt #(.W(2)) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_state_next != r_state),
        .i_load_val (w_wait_load),
        .o_done     (w_wait_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: instruction sequencing and decode dispatch
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RST:     w_state_next = S_FETCH;
            S_FETCH:   w_state_next = S_FETCH_W;
            S_FETCH_W: if (w_wait_done) w_state_next = S_FETCH_L;
            S_FETCH_L: w_state_next = S_DECODE;
            S_DECODE: begin
                case (bus.OPCODE)
                    OP_RTYPE:      w_state_next = S_EXEC_R;
                    OP_ADDI:       w_state_next = S_EXEC_I;
                    OP_LW, OP_SW:  w_state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
                    OP_J:          w_state_next = S_JUMP;
                    default:       w_state_next = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                if (!w_funct_known) begin
                    w_state_next = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
                end else if (bus.Of && ((bus.funct == FN_ADD) || (bus.funct == FN_SUB))) begin
                    w_state_next = S_TRAP;
`endif
                end else begin
                    w_state_next = S_WB_R;
                end
            end
            S_EXEC_I: begin
`ifdef OVERFLOW_TRAP_EN
                w_state_next = bus.Of ? S_TRAP : S_WB_I;
`else
                w_state_next = S_WB_I;
`endif
            end
            S_MEM_ADDR: w_state_next = (bus.OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (w_wait_done) w_state_next = S_MDR_LD;
            S_MDR_LD:   w_state_next = S_WB_M;
            default:    w_state_next = S_FETCH;
        endcase
    end

    // Output decode: every field not set for a state stays 0
    always_comb begin
        w_out = '0;
        case (r_state)
            S_RST: begin
                w_out.reg_w    = 1'b1;
                w_out.m_wreg   = WREG_29;
                w_out.memtoreg = MTR_SP;
            end
            S_FETCH, S_FETCH_W: begin
                w_out.i_or_d = 1'b0;
                w_out.m_ulaa = ULAA_PC;
                w_out.m_ulab = ULAB_FOUR;
                w_out.ula_c  = ULA_ADD;
            end
            S_FETCH_L: begin
                w_out.ir_w      = 1'b1;
                w_out.pc_w      = 1'b1;
                w_out.pc_source = PCS_ULA;
            end
            S_DECODE: begin
                w_out.ab_w     = 1'b1;
                w_out.aluout_w = 1'b1;
                w_out.m_ulaa   = ULAA_PC;
                w_out.m_ulab   = ULAB_SEXT_SH;
                w_out.ula_c    = ULA_ADD;
            end
            S_EXEC_R: begin
                w_out.m_ulaa   = ULAA_A;
                w_out.m_ulab   = ULAB_B;
                w_out.aluout_w = 1'b1;
                w_out.ula_c    = funct_to_ula(bus.funct);
            end
            S_WB_R: begin
                w_out.reg_w    = 1'b1;
                w_out.m_wreg   = WREG_RD;
                w_out.memtoreg = MTR_ALUOUT;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                w_out.m_ulaa   = ULAA_A;
                w_out.m_ulab   = ULAB_SEXT;
                w_out.ula_c    = ULA_ADD;
                w_out.aluout_w = 1'b1;
            end
            S_WB_I: begin
                w_out.reg_w    = 1'b1;
                w_out.m_wreg   = WREG_RT;
                w_out.memtoreg = MTR_ALUOUT;
            end
            S_MEM_RD: w_out.i_or_d = 1'b1;
            S_MDR_LD: w_out.mdr_w  = 1'b1;
            S_WB_M: begin
                w_out.reg_w    = 1'b1;
                w_out.m_wreg   = WREG_RT;
                w_out.memtoreg = MTR_MDR;
            end
            S_MEM_WR: begin
                w_out.i_or_d = 1'b1;
                w_out.mem_w  = 1'b1;
            end
            S_BRANCH: begin
                w_out.m_ulaa = ULAA_A;
                w_out.m_ulab = ULAB_B;
                w_out.ula_c  = ULA_SUB;
                if (w_branch_taken) begin
                    w_out.pc_w      = 1'b1;
                    w_out.pc_source = PCS_ALUOUT;
                end
            end
            S_JUMP: begin
                w_out.pc_w      = 1'b1;
                w_out.pc_source = PCS_JUMP;
            end
`ifdef OVERFLOW_TRAP_EN
            S_TRAP: begin
                w_out.epc_w     = 1'b1;
                w_out.m_ulaa    = ULAA_PC;
                w_out.m_ulab    = ULAB_FOUR;
                w_out.ula_c     = ULA_SUB;
                w_out.pc_w      = 1'b1;
                w_out.pc_source = PCS_EXC;
            end
`endif
            default: w_out = '0;
        endcase
    end

    // Reset suppresses every enable immediately, aborting the instruction
    assign w_out_gated = reset ? '0 : w_out;

    assign bus.PC_w      = w_out_gated.pc_w;
    assign bus.MEM_w     = w_out_gated.mem_w;
    assign bus.IR_w      = w_out_gated.ir_w;
    assign bus.Reg_w     = w_out_gated.reg_w;
    assign bus.AB_w      = w_out_gated.ab_w;
    assign bus.aluOut_w  = w_out_gated.aluout_w;
    assign bus.MDR_w     = w_out_gated.mdr_w;
    assign bus.EPC_w     = w_out_gated.epc_w;
    assign bus.ULA_c     = w_out_gated.ula_c;
    assign bus.M_ULAA    = w_out_gated.m_ulaa;
    assign bus.M_ULAB    = w_out_gated.m_ulab;
    assign bus.M_WREG    = w_out_gated.m_wreg;
    assign bus.MemtoReg  = w_out_gated.memtoreg;
    assign bus.PC_source = w_out_gated.pc_source;
    assign bus.i_or_d    = w_out_gated.i_or_d;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. A per-instruction reference
// model expands each instruction into its expected control word per cycle;
// every cycle the DUT's control word is compared against it.
module tb_multicycle_ctrl_fsm;

    localparam int MEM_WAIT = 2;

    typedef struct packed {
        logic       pc_w;
        logic       mem_w;
        logic       ir_w;
        logic       reg_w;
        logic       ab_w;
        logic       aluout_w;
        logic       mdr_w;
        logic       epc_w;
        logic [2:0] ula_c;
        logic       m_ulaa;
        logic [1:0] m_ulab;
        logic [1:0] m_wreg;
        logic [1:0] memtoreg;
        logic [1:0] pc_source;
        logic       i_or_d;
    } cw_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    cw_t  exp_q[$];

    multicycle_ctrl_fsm_if u_if();

    multicycle_ctrl_fsm #(.MEM_WAIT(MEM_WAIT), .SP_INIT(227)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic cw_t sample_cw();
        cw_t w;
        w.pc_w      = u_if.PC_w;
        w.mem_w     = u_if.MEM_w;
        w.ir_w      = u_if.IR_w;
        w.reg_w     = u_if.Reg_w;
        w.ab_w      = u_if.AB_w;
        w.aluout_w  = u_if.aluOut_w;
        w.mdr_w     = u_if.MDR_w;
        w.epc_w     = u_if.EPC_w;
        w.ula_c     = u_if.ULA_c;
        w.m_ulaa    = u_if.M_ULAA;
        w.m_ulab    = u_if.M_ULAB;
        w.m_wreg    = u_if.M_WREG;
        w.memtoreg  = u_if.MemtoReg;
        w.pc_source = u_if.PC_source;
        w.i_or_d    = u_if.i_or_d;
        return w;
    endfunction

    function automatic cw_t rst_word();
        cw_t w = '0;
        w.reg_w = 1'b1; w.m_wreg = 2'd2; w.memtoreg = 2'd2;
        return w;
    endfunction

    // Expected control words for one instruction, FETCH entry through its
    // last cycle, built from the per-instruction cycle tables.
    task automatic build_expect(input logic [5:0] op, input logic [5:0] fn,
                                input logic of, input logic zr);
        cw_t w;
        logic [2:0] alu;
        logic trap;
        exp_q.delete();
        // fetch + memory wait: address from PC, ALU = PC + 4
        w = '0; w.ula_c = 3'd1; w.m_ulab = 2'd1;
        for (int k = 0; k < 1 + MEM_WAIT; k++) exp_q.push_back(w);
        w = '0; w.ir_w = 1'b1; w.pc_w = 1'b1; exp_q.push_back(w);
        w = '0; w.ab_w = 1'b1; w.aluout_w = 1'b1; w.m_ulab = 2'd3; w.ula_c = 3'd1;
        exp_q.push_back(w);
        case (op)
            6'h00: begin
                alu = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 : 3'd0;
                w = '0; w.m_ulaa = 1'b1; w.aluout_w = 1'b1; w.ula_c = alu;
                exp_q.push_back(w);
`ifdef OVERFLOW_TRAP_EN
                trap = of && (alu == 3'd1 || alu == 3'd2);
`else
                trap = 1'b0;
`endif
                if (alu != 3'd0) begin
                    w = '0;
                    if (trap) begin
                        w.epc_w = 1'b1; w.m_ulab = 2'd1; w.ula_c = 3'd2;
                        w.pc_w = 1'b1; w.pc_source = 2'd3;
                    end else begin
                        w.reg_w = 1'b1; w.m_wreg = 2'd1;
                    end
                    exp_q.push_back(w);
                end
            end
            6'h08: begin
                w = '0; w.m_ulaa = 1'b1; w.m_ulab = 2'd2; w.ula_c = 3'd1; w.aluout_w = 1'b1;
                exp_q.push_back(w);
`ifdef OVERFLOW_TRAP_EN
                trap = of;
`else
                trap = 1'b0;
`endif
                w = '0;
                if (trap) begin
                    w.epc_w = 1'b1; w.m_ulab = 2'd1; w.ula_c = 3'd2;
                    w.pc_w = 1'b1; w.pc_source = 2'd3;
                end else begin
                    w.reg_w = 1'b1;
                end
                exp_q.push_back(w);
            end
            6'h23, 6'h2B: begin
                w = '0; w.m_ulaa = 1'b1; w.m_ulab = 2'd2; w.ula_c = 3'd1; w.aluout_w = 1'b1;
                exp_q.push_back(w);
                if (op == 6'h23) begin
                    w = '0; w.i_or_d = 1'b1;
                    for (int k = 0; k < MEM_WAIT + 1; k++) exp_q.push_back(w);
                    w = '0; w.mdr_w = 1'b1; exp_q.push_back(w);
                    w = '0; w.reg_w = 1'b1; w.memtoreg = 2'd1; exp_q.push_back(w);
                end else begin
                    w = '0; w.i_or_d = 1'b1; w.mem_w = 1'b1; exp_q.push_back(w);
                end
            end
            6'h04, 6'h05: begin
                w = '0; w.m_ulaa = 1'b1; w.ula_c = 3'd2;
                if ((op == 6'h04) ? zr : !zr) begin
                    w.pc_w = 1'b1; w.pc_source = 2'd1;
                end
                exp_q.push_back(w);
            end
            6'h02: begin
                w = '0; w.pc_w = 1'b1; w.pc_source = 2'd2; exp_q.push_back(w);
            end
            default: ;
        endcase
    endtask

    // Run one instruction starting in its FETCH cycle (#1 after the edge).
    // With abort set, reset is raised during the instruction's last cycle.
    task automatic run_instr(input int n, input logic [5:0] op, input logic [5:0] fn,
                             input logic of, input logic zr, input logic abort);
        int len;
        build_expect(op, fn, of, zr);
        len = exp_q.size();
        u_if.OPCODE = op; u_if.funct = fn; u_if.Of = of; u_if.Zr = zr;
        $display("instr %0d op=%02h fn=%02h of=%0b zr=%0b cycles=%0d abort=%0b",
                 n, op, fn, of, zr, len, abort);
        for (int k = 0; k < len; k++) begin
            check($sformatf("i%0d_op%02h_c%0d", n, op, k), 32'(sample_cw()), 32'(exp_q[k]));
            if (abort && k == len - 1) begin
                reset = 1'b1;
                #1;
                check($sformatf("i%0d_memw_on_reset", n), 32'(u_if.MEM_w), 32'd0);
                @(posedge clk); #1;
                check($sformatf("i%0d_reset_held", n), 32'(sample_cw()), 32'd0);
                reset = 1'b0;
                #1;
                check($sformatf("i%0d_rst_after_abort", n), 32'(sample_cw()), 32'(rst_word()));
            end
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] d_op[9]  = '{6'h00, 6'h23, 6'h04, 6'h04, 6'h05, 6'h3F, 6'h08, 6'h02, 6'h2B};
    logic [5:0] d_fn[9]  = '{6'h22, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h00, 6'h00, 6'h00};
    logic       d_of[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       d_zr[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [5:0] ops_tbl[10] = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h11};
    logic [5:0] fn_tbl[5]   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00};

    initial begin
        u_if.OPCODE = 6'h00; u_if.funct = 6'h00; u_if.Of = 1'b0; u_if.Zr = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_t0", 32'(sample_cw()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("reset_hold%0d", k), 32'(sample_cw()), 32'd0);
        end
        reset = 1'b0;
        #1;
        check("rst_state", 32'(sample_cw()), 32'(rst_word()));
        @(posedge clk); #1;

        // directed: sub, lw, beq taken/not, bne taken, illegal, addi+Of, j, sw aborted
        for (int n = 0; n < 9; n++) begin
            run_instr(n, d_op[n], d_fn[n], d_of[n], d_zr[n], n == 8);
        end

        // random instruction stream
        for (int n = 9; n < 309; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops_tbl[$urandom_range(0, 9)];
            fn = fn_tbl[$urandom_range(0, 4)];
            run_instr(n, op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      (op == 6'h2B) && ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
